// File: rtl/relm_fp_sched.sv
// relm_fp_sched
//   Round-robin scheduler sharing one combinational relm_custom FP unit among
//   NREQ requesters. Two-pass commands (FADD/FSUB/FMUL/ITOF) run an OPB
//   pre-pass followed by an ITOF normalize/round pass; FCOMP is single-pass.
//   All unit inputs are registered, so the unit never sees glitching inputs.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready is a one-hot grant)
//   req_cmd               3 bits per requester: 0 FADD 1 FSUB 2 FMUL 3 ITOF 4 FCOMP
//   req_a, req_b          WD-bit operands per requester
//   rsp_valid/rsp_ready   shared response handshake
//   rsp_id, rsp_data      owner and result of the response
//   rsp_err               illegal command flag
//   fu_op..fu_cb          registered unit inputs (op_in, opb_in, a_in, xb_in, x_in, cb_in)
//   fu_a_res, fu_cb_res   unit outputs a_out, cb_out
module relm_fp_sched #(
  parameter int NREQ = 4,
  parameter int WD   = 32,
  parameter int WOP  = 5,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [3*NREQ-1:0]    req_cmd,
  input  logic [WD*NREQ-1:0]   req_a,
  input  logic [WD*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [WD-1:0]        rsp_data,
  output logic                 rsp_err,
  output logic [WOP-1:0]       fu_op,
  output logic                 fu_opb,
  output logic [WD-1:0]        fu_a,
  output logic [WD-1:0]        fu_xb,
  output logic [WD-1:0]        fu_x,
  output logic [WD-1:0]        fu_cb,
  input  logic [WD-1:0]        fu_a_res,
  input  logic [WD-1:0]        fu_cb_res
);

  localparam logic [2:0] CMD_FADD  = 3'd0;
  localparam logic [2:0] CMD_FSUB  = 3'd1;
  localparam logic [2:0] CMD_FMUL  = 3'd2;
  localparam logic [2:0] CMD_ITOF  = 3'd3;
  localparam logic [2:0] CMD_FCOMP = 3'd4;

  localparam logic [WOP-1:0] OP_ADD  = WOP'(3'b000);
  localparam logic [WOP-1:0] OP_MUL  = WOP'(3'b001);
  localparam logic [WOP-1:0] OP_NORM = WOP'(3'b100);
  localparam logic [WOP-1:0] OP_CMP  = WOP'(3'b110);

  // ISIGN select lives in the x field just above the opcode bits
  localparam logic [WD-1:0] X_ISIGN = WD'(1) << (WOP + 1);

  typedef enum logic [1:0] {S_IDLE, S_P1, S_P2, S_RSP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [2:0]      cmd_r;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gnt_id;
  logic            accept;
  logic            two_pass;
  logic [2:0]      sel_cmd;
  logic [WD-1:0]   sel_a;
  logic [WD-1:0]   sel_b;

  // Round-robin search starting at rr_ptr; first valid requester wins
  always_comb begin
    logic [IW-1:0] idx;
    grant  = '0;
    gnt_id = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'((32'(rr_ptr) + k) % 32'(NREQ));
      if (grant == '0 && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gnt_id     = idx;
      end
    end
  end

  // Gated by rst_n so no grant is advertised while reset is held
  assign req_ready = (state == S_IDLE && rst_n) ? grant : '0;
  assign accept    = (state == S_IDLE) && (grant != '0);
  assign rsp_valid = (state == S_RSP);
  assign fu_cb     = fu_xb;
  assign two_pass  = (cmd_r <= CMD_ITOF);

  assign sel_cmd = req_cmd[32'(gnt_id)*3 +: 3];
  assign sel_a   = req_a[32'(gnt_id)*WD +: WD];
  assign sel_b   = req_b[32'(gnt_id)*WD +: WD];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_P1;
      S_P1:    state_nxt = two_pass ? S_P2 : S_RSP;
      S_P2:    state_nxt = S_RSP;
      S_RSP:   if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      rsp_id   <= '0;
      cmd_r    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      fu_op    <= '0;
      fu_opb   <= 1'b0;
      fu_a     <= '0;
      fu_xb    <= '0;
      fu_x     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rsp_id <= gnt_id;
            cmd_r  <= sel_cmd;
            fu_a   <= sel_a;
            fu_xb  <= sel_b;
            fu_x   <= '0;
            case (sel_cmd)
              CMD_FADD: begin
                fu_op  <= OP_ADD;
                fu_opb <= 1'b1;
              end
              CMD_FSUB: begin
                fu_op  <= OP_ADD;
                fu_opb <= 1'b1;
                fu_xb  <= {~sel_b[WD-1], sel_b[WD-2:0]};
              end
              CMD_FMUL: begin
                fu_op  <= OP_MUL;
                fu_opb <= 1'b1;
              end
              CMD_ITOF: begin
                fu_op  <= OP_NORM;
                fu_opb <= 1'b1;
                fu_xb  <= '0;
                fu_x   <= X_ISIGN;
              end
              CMD_FCOMP: begin
                fu_op  <= OP_CMP;
                fu_opb <= 1'b0;
              end
              default: begin
                fu_op  <= OP_CMP;
                fu_opb <= 1'b0;
                fu_a   <= '0;
                fu_xb  <= '0;
              end
            endcase
          end
        end
        S_P1: begin
          if (two_pass) begin
            // Pre-pass result feeds the normalize/round pass
            fu_a   <= fu_a_res;
            fu_xb  <= fu_cb_res;
            fu_op  <= OP_NORM;
            fu_opb <= 1'b0;
            fu_x   <= '0;
          end else if (cmd_r == CMD_FCOMP) begin
            rsp_data <= fu_a_res;
          end else begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        S_P2: rsp_data <= fu_a_res;
        S_RSP: begin
          if (rsp_ready) begin
            rsp_err <= 1'b0;
            rr_ptr  <= (rsp_id == IW'(NREQ - 1)) ? '0 : rsp_id + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_relm_fp_sched.sv
// Self-checking bench for relm_fp_sched with a table-driven stand-in for the
// relm_custom unit and a transaction-level model of the scheduler.
module tb_relm_fp_sched;
  localparam int NREQ = 4;
  localparam int WD   = 32;
  localparam int WOP  = 5;
  localparam int IW   = 2;
  localparam logic [31:0] K = 32'h0000_1234;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [3*NREQ-1:0]   req_cmd;
  logic [WD*NREQ-1:0]  req_a;
  logic [WD*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [WD-1:0]       rsp_data;
  logic                rsp_err;
  logic [WOP-1:0]      fu_op;
  logic                fu_opb;
  logic [WD-1:0]       fu_a;
  logic [WD-1:0]       fu_xb;
  logic [WD-1:0]       fu_x;
  logic [WD-1:0]       fu_cb;
  logic [WD-1:0]       fu_a_res;
  logic [WD-1:0]       fu_cb_res;

  int checks = 0;
  int errors = 0;

  relm_fp_sched #(.NREQ(NREQ), .WD(WD), .WOP(WOP), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .fu_op(fu_op), .fu_opb(fu_opb), .fu_a(fu_a), .fu_xb(fu_xb), .fu_x(fu_x),
    .fu_cb(fu_cb), .fu_a_res(fu_a_res), .fu_cb_res(fu_cb_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- unit stand-in ----------------
  // Exact results for the vectors under test; a deterministic hash otherwise.
  function automatic logic [31:0] ref1(input logic [4:0] op, input logic isign,
                                       input logic [31:0] a, input logic [31:0] xb);
    if (op == 5'd0 && !isign && a == 32'h3F800000 && xb == 32'h40000000) return 32'h40400000;
    if (op == 5'd0 && !isign && a == 32'h40400000 && xb == 32'hBF800000) return 32'h40000000;
    if (op == 5'd1 && !isign && a == 32'h40000000 && xb == 32'h40400000) return 32'h40C00000;
    if (op == 5'd4 && isign && a == 32'h00000005 && xb == 32'h0) return 32'h40A00000;
    if (op == 5'd4 && isign && a == 32'hFFFFFFFD && xb == 32'h0) return 32'hC0400000;
    return a ^ {xb[15:0], xb[31:16]} ^ {op, 27'd0} ^ (isign ? 32'h0F0F0000 : 32'h0);
  endfunction

  function automatic logic [31:0] cmp_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'hFFFFFFFF;
    return a ^ ~b;
  endfunction

  // Pre-pass leaves R+K / K so the second pass only recovers R if both
  // intermediate words are forwarded.
  function automatic logic [31:0] unit_a(input logic [4:0] op, input logic opb,
                                         input logic [31:0] a, input logic [31:0] xb,
                                         input logic [31:0] x);
    if (opb) return ref1(op, x[WOP+1], a, xb) + K;
    if (op == 5'd4) return a - xb;
    if (op == 5'd6) return cmp_ref(a, xb);
    return 32'hBAD0BAD0;
  endfunction

  assign fu_a_res  = unit_a(fu_op, fu_opb, fu_a, fu_xb, fu_x);
  assign fu_cb_res = fu_opb ? K : 32'h0;

  // ---------------- scheduler model ----------------
  function automatic logic [NREQ-1:0] rr_grant(input int rr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(rr + k) % NREQ]) return NREQ'(1) << ((rr + k) % NREQ);
    return '0;
  endfunction

  task automatic p1_exp(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [4:0] op, output logic opb,
                        output logic [31:0] ea, output logic [31:0] exb, output logic [31:0] ex);
    op = 5'd0; opb = 1'b1; ea = a; exb = b; ex = 32'h0;
    case (c)
      3'd0: ;
      3'd1: exb = b ^ 32'h80000000;
      3'd2: op = 5'd1;
      3'd3: begin op = 5'd4; exb = 32'h0; ex = 32'h1 << (WOP + 1); end
      3'd4: begin op = 5'd6; opb = 1'b0; end
      default: begin op = 5'd6; opb = 1'b0; ea = 32'h0; exb = 32'h0; end
    endcase
  endtask

  int          m_phase = 0;   // 0 waiting for grant, 1 in flight, 2 response pending
  int          m_step  = 0;
  int          m_rr    = 0;
  int          m_id    = 0;
  logic [2:0]  m_cmd;
  logic [31:0] m_a, m_b;

  always @(negedge clk) begin
    logic [4:0]      eop;
    logic            eopb;
    logic [31:0]     ea, exb, ex, eres;
    logic [NREQ-1:0] eg;
    if (!rst_n) begin
      m_phase = 0;
      m_rr    = 0;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_id",    32'(rsp_id),    32'h0);
      chk("rst_rsp_data",  rsp_data,       32'h0);
      chk("rst_rsp_err",   32'(rsp_err),   32'h0);
      chk("rst_fu_op",     32'(fu_op),     32'h0);
      chk("rst_fu_opb",    32'(fu_opb),    32'h0);
      chk("rst_fu_a",      fu_a,           32'h0);
      chk("rst_fu_xb",     fu_xb,          32'h0);
      chk("rst_fu_x",      fu_x,           32'h0);
    end else begin
      chk("cb_tracks_xb", fu_cb, fu_xb);
      p1_exp(m_cmd, m_a, m_b, eop, eopb, ea, exb, ex);
      case (m_phase)
        0: begin
          eg = rr_grant(m_rr, req_valid);
          chk("req_ready", 32'(req_ready), 32'(eg));
          chk("rsp_valid_idle", 32'(rsp_valid), 32'h0);
          if (eg != '0) begin
            for (int i = 0; i < NREQ; i++) if (eg[i]) m_id = i;
            m_cmd   = req_cmd[m_id*3 +: 3];
            m_a     = req_a[m_id*32 +: 32];
            m_b     = req_b[m_id*32 +: 32];
            m_step  = 0;
            m_phase = 1;
          end
        end
        1: begin
          m_step++;
          chk("req_ready_busy", 32'(req_ready), 32'h0);
          chk("rsp_valid_busy", 32'(rsp_valid), 32'h0);
          if (m_step == 1) begin
            chk("p1_op",  32'(fu_op),  32'(eop));
            chk("p1_opb", 32'(fu_opb), 32'(eopb));
            chk("p1_a",   fu_a,  ea);
            chk("p1_xb",  fu_xb, exb);
            chk("p1_x",   fu_x,  ex);
          end else begin
            chk("p2_op",  32'(fu_op),  32'h4);
            chk("p2_opb", 32'(fu_opb), 32'h0);
            chk("p2_x",   fu_x,  32'h0);
            chk("p2_a",   fu_a,  ref1(eop, ex[WOP+1], ea, exb) + K);
            chk("p2_xb",  fu_xb, K);
          end
          if (m_step == ((m_cmd <= 3'd3) ? 2 : 1)) m_phase = 2;
        end
        default: begin
          if (m_cmd <= 3'd3)      eres = ref1(eop, ex[WOP+1], ea, exb);
          else if (m_cmd == 3'd4) eres = cmp_ref(m_a, m_b);
          else                    eres = 32'h0;
          chk("rsp_valid", 32'(rsp_valid), 32'h1);
          chk("rsp_id",    32'(rsp_id),    32'(m_id));
          chk("rsp_data",  rsp_data,       eres);
          chk("rsp_err",   32'(rsp_err),   32'(m_cmd > 3'd4));
          chk("req_ready_rsp", 32'(req_ready), 32'h0);
          if (rsp_ready) begin
            m_rr    = (m_id + 1) % NREQ;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int id, input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    req_cmd[id*3 +: 3] = cmd;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
  endtask

  task automatic wait_grant(input int id);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[id] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[id]) fail_now("grant_wait");
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    if (!rsp_valid) fail_now("rsp_wait");
  endtask

  task automatic run_one(input int id, input logic [2:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit, input logic lerr,
                         input int lat);
    int n;
    @(posedge clk); #1;
    set_req(id, cmd, a, b);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    wait_grant(id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    wait_rsp(n);
    chk("lit_latency", 32'(n), 32'(lat));
    chk("lit_data", rsp_data, lit);
    chk("lit_err", 32'(rsp_err), 32'(lerr));
    chk("lit_id", 32'(rsp_id), 32'(id));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, gcnt;
    int ids [5];
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_cmd   = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors
    run_one(0, 3'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 3);
    run_one(1, 3'd1, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 3);
    run_one(2, 3'd2, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 3);
    run_one(3, 3'd3, 32'h00000005, 32'h0,        32'h40A00000, 1'b0, 3);
    run_one(0, 3'd3, 32'hFFFFFFFD, 32'h0,        32'hC0400000, 1'b0, 3);
    run_one(1, 3'd4, 32'h3F800000, 32'h40000000, 32'hFFFFFFFF, 1'b0, 2);
    run_one(2, 3'd7, 32'h12345678, 32'h9ABCDEF0, 32'h0,        1'b1, 2);

    // Fairness from a fresh reset with every requester valid
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, 32'h100 * (i + 1), 32'(i));
    req_valid = '1;
    cnt = 0; gcnt = 0; n = 0;
    while (cnt < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (req_ready != '0) begin
        gcnt++;
        chk("grant_onehot", 32'($onehot(req_ready)), 32'h1);
      end
      if (rsp_valid) begin
        ids[cnt] = int'(rsp_id);
        cnt++;
      end
    end
    if (cnt < 5) fail_now("fair_rsp");
    @(posedge clk); #1 req_valid = '0;
    chk("fair_id0", 32'(ids[0]), 32'd0);
    chk("fair_id1", 32'(ids[1]), 32'd1);
    chk("fair_id2", 32'(ids[2]), 32'd2);
    chk("fair_id3", 32'(ids[3]), 32'd3);
    chk("fair_id4", 32'(ids[4]), 32'd0);
    chk("fair_grants", 32'(gcnt), 32'd5);

    // Backpressure: response held, no new grant while it waits
    rsp_ready = 1'b0;
    set_req(2, 3'd2, 32'h40000000, 32'h40400000);
    set_req(3, 3'd4, 32'h3F800000, 32'h40000000);
    req_valid = 4'b1100;
    wait_grant(2);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    wait_rsp(n);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_data", rsp_data, 32'h40C00000);
      chk("bp_no_grant", 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_resume_grant", 32'(req_ready), 32'h8);
    @(posedge clk); #1 req_valid[3] = 1'b0;
    wait_rsp(n);
    chk("bp_next_data", rsp_data, 32'hFFFFFFFF);
    chk("bp_next_id", 32'(rsp_id), 32'd3);

    // Reset during P2 of a two-pass request
    run_one(0, 3'd3, 32'h00000005, 32'h0, 32'h40A00000, 1'b0, 3);
    @(posedge clk); #1;
    set_req(2, 3'd0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0100;
    wait_grant(2);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("abort_rsp_id", 32'(rsp_id), 32'h0);
    chk("abort_fu_a", fu_a, 32'h0);
    chk("abort_fu_op", 32'(fu_op), 32'h0);
    set_req(0, 3'd3, 32'hFFFFFFFD, 32'h0);
    set_req(1, 3'd0, 32'h1, 32'h2);
    set_req(3, 3'd0, 32'h3, 32'h4);
    req_valid = '1;
    @(posedge clk); #1 rst_n = 1'b1;
    #1 chk("abort_first_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(n);
    chk("abort_next_id", 32'(rsp_id), 32'd0);
    chk("abort_next_data", rsp_data, 32'hC0400000);
    chk("abort_next_lat", 32'(n), 32'd3);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/relm_fp_sched.md
# relm_fp_sched

Round-robin scheduler that shares one combinational `relm_custom` floating-point unit among `NREQ` requesters. It sequences two-pass operations through the unit: an OPB pre-pass (FADD/FMUL/ISIGN) followed by an ITOF normalize/round pass, and single-pass operations (FCOMP). It registers all unit inputs and returns one result per accepted request on a shared response port with backpressure.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WD`, 32: data width. The unit's FP field layout requires 32.
- `WOP`, 5: unit opcode width. Also sets the position of the `x` select bits `[WOP+1:WOP]`.
- `IW`, `$clog2(NREQ)`: requester id width (derived).

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request present, per requester.
- `req_cmd`  in  3*NREQ  command per requester: 0 FADD, 1 FSUB, 2 FMUL, 3 ITOF (signed int to float), 4 FCOMP, 5..7 illegal.
- `req_a`  in  WD*NREQ  operand a.
- `req_b`  in  WD*NREQ  operand b (unused for ITOF).
- `req_ready`  out  NREQ  one-hot grant. A request is accepted on `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  IW  requester that owns the result.
- `rsp_data`  out  WD  result word.
- `rsp_err`  out  1  set for an illegal command.
- `fu_op`  out  WOP  drives unit `op_in`. Only bits [2:0] are non-zero.
- `fu_opb`  out  1  drives unit `opb_in`.
- `fu_a`  out  WD  drives unit `a_in`.
- `fu_xb`  out  WD  drives unit `xb_in`.
- `fu_x`  out  WD  drives unit `x_in`. Only bit `WOP+1` is ever set.
- `fu_cb`  out  WD  drives unit `cb_in`. Always equals `fu_xb`.
- `fu_a_res`  in  WD  unit `a_out`.
- `fu_cb_res`  in  WD  unit `cb_out`.

## Operation
States: IDLE, P1, P2, RSP.

- **IDLE**
  - `req_ready` is the round-robin grant. Search starts at `rr_ptr` and takes the first `i` with `req_valid[i]`. All bits are 0 outside IDLE.
  - On handshake: latch id, cmd and operands, load the pass-1 `fu_*` registers, go to P1.
- **Pass-1 load, by command**
  - FADD: op=000, opb=1, a=`a`, xb=`b`.
  - FSUB: same as FADD with xb=`{~b[31], b[30:0]}`.
  - FMUL: op=001, opb=1, a=`a`, xb=`b`.
  - ITOF: op=100, opb=1, `fu_x[WOP+1]`=1 (ISIGN), a=`a`, xb=0.
  - FCOMP: op=110, opb=0, a=`a`, xb=`b`.
  - Illegal: op=110, opb=0, operands 0.
- **P1** (unit output valid combinationally)
  - FADD/FSUB/FMUL/ITOF: `fu_a<=fu_a_res`, `fu_xb<=fu_cb_res`, op=100, opb=0, `fu_x`=0. Go to P2.
  - FCOMP: `rsp_data<=fu_a_res`. Go to RSP.
  - Illegal: `rsp_data<=0`, `rsp_err<=1`. Go to RSP.
- **P2**: `rsp_data<=fu_a_res`. Go to RSP.
- **RSP**
  - `rsp_valid`=1. `rsp_id`, `rsp_data` and `rsp_err` stay stable until `rsp_ready`.
  - On `rsp_ready`: go to IDLE, clear `rsp_err`, set `rr_ptr<=(id+1) mod NREQ`.

`fu_*` registers hold their last value in IDLE and RSP. The unit therefore sees no glitching inputs.

Reset values (async, `rst_n`=0):
- State IDLE, `rr_ptr`=0.
- `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0.
- All `fu_*`=0.
- `req_ready`=0 while in reset.

Reset mid-operation aborts the operation; no response is ever produced for it.

## Timing
- Handshake at edge k. P1 occupies cycle k+1.
- Two-pass commands: P2 at cycle k+2, `rsp_valid` high from cycle k+3.
- FCOMP and illegal: `rsp_valid` high from cycle k+2.
- Next grant is possible in the cycle after the `rsp_ready` edge. Minimum spacing between accepts: 4 cycles for two-pass commands, 3 cycles for single-pass commands.
- Requester-side rules:
  - A requester must hold `req_valid`, `req_cmd` and operands until it is granted.
  - Deasserting `req_valid` before the grant is legal; the grant moves to the next requester that is valid.
- `req_ready` is combinational from `req_valid` and state. There is no combinational path from `fu_*_res` to any output.
- Fairness: with all requesters valid, grant order is 0, 1, …, NREQ-1, 0. Each requester waits at most NREQ-1 operations.

## Test plan
- FADD, req 0, a=32'h3F800000, b=32'h40000000 -> `rsp_data`=32'h40400000, `rsp_id`=0, `rsp_valid` at k+3.
- FSUB, req 1, a=32'h40400000, b=32'h3F800000 -> 32'h40000000. FMUL, a=32'h40000000, b=32'h40400000 -> 32'h40C00000.
- ITOF, a=5 -> 32'h40A00000. ITOF, a=32'hFFFFFFFD -> 32'hC0400000. FCOMP, 1.0 vs 2.0 -> 32'hFFFFFFFF at k+2. Illegal cmd 7 -> `rsp_data`=0, `rsp_err`=1.
- All 4 requesters valid continuously, `rsp_ready`=1 -> `rsp_id` sequence 0,1,2,3,0. Each `req_ready` pulse is one cycle and one-hot.
- `rsp_ready` held 0 for 5 cycles -> `rsp_valid`/`rsp_data` stable and no new grant. Accept resumes the cycle after `rsp_ready`.
- `rst_n` pulsed low during P2 -> all outputs return to reset values immediately, no response for the aborted request, next grant starts at requester 0.
